// File: rtl/ysyx_23060201_if_id_buf.sv
// ysyx_23060201_if_id_buf
// Two-entry fetch-to-decode skid buffer. Beats {pc, inst} enter from fetch
// under valid/ready, leave toward decode in strict FIFO order, and are all
// discarded by flush when a taken jump/branch redirects fetch.
// Both handshake outputs are derived only from registered state, so there is
// no combinational path from in_* to out_* or from out_ready to in_ready.
// Optional feature macro: IFID_PERF_EN adds stall and flush event counters.
module ysyx_23060201_if_id_buf #(
    parameter int                    MEM_ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INST       = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0]     in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MEM_ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0]     out_inst
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
`endif
);

    // Occupancy doubles as the state: the encoding equals the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_pc0;
    logic [DATA_WIDTH-1:0]     r_inst0;
    logic [MEM_ADDR_WIDTH-1:0] r_pc1;
    logic [DATA_WIDTH-1:0]     r_inst1;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_load_head_from_in;
    logic w_load_head_from_tail;
    logic w_load_tail_from_in;

    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);

    // flush suppresses both handshakes in the same cycle
    assign w_push = in_valid && w_in_ready && !flush;
    assign w_pop  = w_out_valid && out_ready && !flush;

    // A new beat becomes the head when the buffer is empty, or when the
    // single held beat is consumed in the same cycle.
    assign w_load_head_from_in   = w_push && ((r_state == ST_EMPTY) ||
                                              ((r_state == ST_ONE) && w_pop));
    assign w_load_head_from_tail = w_pop && (r_state == ST_FULL);
    assign w_load_tail_from_in   = w_push && (r_state == ST_ONE) && !w_pop;

    // Occupancy state machine; flush always returns to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        r_state <= ST_FULL;
                    end else if (!w_push && w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Head slot: loaded from fetch or shifted up from the tail; otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc0   <= '0;
            r_inst0 <= NOP_INST;
        end else if (w_load_head_from_in) begin
            r_pc0   <= in_pc;
            r_inst0 <= in_inst;
        end else if (w_load_head_from_tail) begin
            r_pc0   <= r_pc1;
            r_inst0 <= r_inst1;
        end
    end

    // Tail slot: written only when a beat arrives behind a stalled head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc1   <= '0;
            r_inst1 <= NOP_INST;
        end else if (w_load_tail_from_in) begin
            r_pc1   <= in_pc;
            r_inst1 <= in_inst;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_pc    = w_out_valid ? r_pc0   : '0;
    assign out_inst  = w_out_valid ? r_inst0 : NOP_INST;

`ifdef IFID_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Count cycles where decode holds off a valid head; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && !flush) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // Count flushes that actually discard held beats; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (flush && w_out_valid) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060201_if_id_buf.sv
// Testbench for ysyx_23060201_if_id_buf.
// A queue of {pc, inst} beats stands in for the buffer contents; outputs are
// compared against it on every falling edge. Perf counters are checked only
// when IFID_PERF_EN is defined.
module tb_ysyx_23060201_if_id_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef IFID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] modelStall;
    logic [31:0] modelFlush;
`endif

    int total;
    int bad;
    logic [63:0] model[$];

    ysyx_23060201_if_id_buf #(
        .MEM_ADDR_WIDTH(32),
        .DATA_WIDTH    (32),
        .NOP_INST      (NOP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_inst (out_inst)
`ifdef IFID_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expPc;
        logic [31:0] expInst;
        expPc   = (model.size() != 0) ? model[0][63:32] : 32'h0;
        expInst = (model.size() != 0) ? model[0][31:0]  : NOP;
        checkValue({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, model.size() != 0});
        checkValue({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, model.size() < 2});
        checkValue({tag, ".out_pc"},    out_pc,   expPc);
        checkValue({tag, ".out_inst"},  out_inst, expInst);
`ifdef IFID_PERF_EN
        checkValue({tag, ".perf_stall"}, perf_stall_cnt, modelStall);
        checkValue({tag, ".perf_flush"}, perf_flush_cnt, modelFlush);
`endif
    endtask

    // Drive one cycle of inputs, advance the reference queue at the rising
    // edge, then compare on the following falling edge.
    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic rdy, input logic fl);
        bit mReady;
        bit mValid;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        mReady = (model.size() < 2);
        mValid = (model.size() != 0);
`ifdef IFID_PERF_EN
        if (mValid && !rdy && !fl) modelStall = modelStall + 32'd1;
        if (fl && mValid)          modelFlush = modelFlush + 32'd1;
`endif
        if (fl) begin
            model.delete();
        end else begin
            if (mValid && rdy) void'(model.pop_front());
            if (v && mReady)   model.push_back({pc, inst});
        end
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Pulse reset low between edges and confirm it acts without a clock.
    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model.delete();
`ifdef IFID_PERF_EN
        modelStall = '0;
        modelFlush = '0;
`endif
        checkOutput(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
`ifdef IFID_PERF_EN
        modelStall = '0;
        modelFlush = '0;
`endif
        #1;
        checkOutput("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming with decode always ready
        applyStimulus("stream0", 1'b1, 32'h8000_0000, 32'h0000_0297, 1'b1, 1'b0);
        applyStimulus("stream1", 1'b1, 32'h8000_0004, 32'h0102_8823, 1'b1, 1'b0);
        applyStimulus("stream2", 1'b1, 32'h8000_0008, 32'h0010_0073, 1'b1, 1'b0);
        applyStimulus("streamDrain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: third beat waits at fetch until space frees up
        applyStimulus("bp0", 1'b1, 32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0);
        applyStimulus("bp1", 1'b1, 32'h8000_0004, 32'h0102_8823, 1'b0, 1'b0);
        applyStimulus("bp2Held", 1'b1, 32'h8000_0008, 32'h0010_0073, 1'b0, 1'b0);
        applyStimulus("bpDrainA", 1'b1, 32'h8000_0008, 32'h0010_0073, 1'b1, 1'b0);
        applyStimulus("bpDrainB", 1'b1, 32'h8000_0008, 32'h0010_0073, 1'b1, 1'b0);
        applyStimulus("bpDrainC", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a beat presented in the flush cycle
        applyStimulus("fl0", 1'b1, 32'h8000_0000, 32'h1111_1111, 1'b0, 1'b0);
        applyStimulus("fl1", 1'b1, 32'h8000_0004, 32'h2222_2222, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 32'h8000_0010, 32'h3333_3333, 1'b0, 1'b1);
        applyStimulus("postFlush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Simultaneous push and pop with one entry held
        applyStimulus("pp0", 1'b1, 32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0);
        applyStimulus("ppBoth", 1'b1, 32'h8000_0004, 32'h0102_8823, 1'b1, 1'b0);
        applyStimulus("ppDrain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while full, then latency-1 restart
        applyStimulus("ar0", 1'b1, 32'h8000_0020, 32'hAAAA_0001, 1'b0, 1'b0);
        applyStimulus("ar1", 1'b1, 32'h8000_0024, 32'hAAAA_0002, 1'b0, 1'b0);
        asyncReset("asyncReset");
        applyStimulus("arFirst", 1'b1, 32'h8000_0030, 32'hBBBB_0001, 1'b0, 1'b0);
        applyStimulus("arDrain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 3) != 0),
                          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                          $urandom,
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_if_id_buf.md
# ysyx_23060201_if_id_buf

Two-entry, fully registered fetch-to-decode buffer between the instruction fetch unit and the decode unit. It takes `{pc, inst}` beats from fetch under a valid/ready handshake, holds them in order, and presents them to decode. It is flushed when a taken jump or branch redirects fetch. Both handshake directions are registered, so there is no combinational path from input to output or from `out_ready` to `in_ready`.

## Interface
- `MEM_ADDR_WIDTH`, 32, width of `pc`.
- `DATA_WIDTH`, 32, width of the instruction word.
- `NOP_INST`, 32'h0000_0013, payload driven on `out_inst` when the buffer is empty (`addi x0,x0,0`).

Clock and reset: one clock, `clk`, with all state updated on its rising edge. Reset `rst_n` is asynchronous and active-low.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  discards all held beats and any incoming beat in this cycle.
- `in_valid`  in  1  fetch presents a beat.
- `in_ready`  out  1  buffer can accept a beat.
- `in_pc`  in  `MEM_ADDR_WIDTH`  pc of the incoming instruction.
- `in_inst`  in  `DATA_WIDTH`  incoming instruction word.
- `out_valid`  out  1  head entry valid toward decode.
- `out_ready`  in  1  decode consumes the head this cycle.
- `out_pc`  out  `MEM_ADDR_WIDTH`  pc of the head entry.
- `out_inst`  out  `DATA_WIDTH`  instruction of the head entry.
- `perf_stall_cnt`  out  32  present only with `IFID_PERF_EN`.
- `perf_flush_cnt`  out  32  present only with `IFID_PERF_EN`.

## Operation
- Storage: two entries (slot 0 = head, slot 1 = tail) plus a 2-bit `count` (0, 1 or 2). States EMPTY (0), ONE (1), FULL (2).
- Push: `in_valid && in_ready && !flush`.
- Pop: `out_valid && out_ready && !flush`.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop → ONE, and the new beat becomes the head.
  - FULL: pop → ONE, with the tail moved to the head. Push is impossible because `in_ready` is 0.
- `flush` has priority over everything else. Next state is EMPTY, with no push and no pop, whatever the current state, `in_valid` or `out_ready`.
- `in_ready` = (`count` != 2). It is derived only from registered state.
- `out_valid` = (`count` != 0).
- When `count` = 0: `out_pc` = 0 and `out_inst` = `NOP_INST`. Otherwise both come from slot 0.
- Ordering is strict FIFO. No beat is duplicated or dropped except by `flush`.
- `in_pc` and `in_inst` are captured unmodified. No alignment check.

## Timing
- Reset (asynchronous assert, synchronous-to-edge release):
  - `count` = 0, `in_ready` = 1, `out_valid` = 0.
  - `out_pc` = 0, `out_inst` = `NOP_INST`.
  - Both perf counters = 0.
- Latency: a beat pushed at rising edge N is visible on `out_*` with `out_valid` = 1 in the cycle following edge N. Minimum latency is 1 cycle.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- A decode stall of one cycle fills the second slot without lowering `in_ready`. `in_ready` falls only in the cycle after the second entry is written.
- A flush at edge N: `out_valid` = 0 and `in_ready` = 1 in the next cycle. A beat presented by fetch in the flush cycle is dropped.
- Reset asserted mid-operation clears all entries immediately, with no wait for a clock edge.
- Payload registers not being loaded hold their value. Only `count` gates their visibility.

## Configuration
- Macro: `IFID_PERF_EN`.
- Defined:
  - `perf_stall_cnt` increments on every cycle with `out_valid && !out_ready && !flush`.
  - `perf_flush_cnt` increments on every cycle with `flush && count != 0`.
  - Both counters are 32-bit and wrap from 32'hFFFF_FFFF to 0. Both are reset by `rst_n`.
- Undefined: both ports and both counters are absent. Datapath behaviour is identical.

## Test plan
- Reset then idle: `rst_n` = 0 → `in_ready` = 1, `out_valid` = 0, `out_inst` = 32'h0000_0013, `out_pc` = 0.
- Streaming: push `{pc, inst}` = `{0x8000_0000, 0x0000_0297}`, `{0x8000_0004, 0x0102_8823}`, `{0x8000_0008, 0x00100073}` on consecutive cycles with `out_ready` = 1 → each beat appears one cycle later, in order, with `in_ready` held at 1.
- Backpressure: `out_ready` = 0 while pushing 3 beats → after the 2nd push `in_ready` = 0 and the 3rd beat is held by fetch. Raising `out_ready` drains `0x8000_0000`, then `0x8000_0004`, then accepts the 3rd beat. No loss.
- Flush while FULL with `in_valid` = 1 (`pc` = 0x8000_0010) → next cycle `out_valid` = 0 and `in_ready` = 1. Beat 0x8000_0010 never appears. With `IFID_PERF_EN`, `perf_flush_cnt` = 1.
- Simultaneous push and pop in ONE (head 0x8000_0000, new 0x8000_0004) → next cycle `count` = 1 and `out_pc` = 0x8000_0004.
- Async reset mid-stream (FULL, `rst_n` pulsed low between edges) → `out_valid` = 0 immediately. The first beat after release appears with latency 1. With `IFID_PERF_EN`, both counters = 0.
